// File: rtl/csr_machine_trap.sv
// Machine-mode CSR file with privilege tracking, HPM counters and a registered
// one-cycle redirect for trap entry and mret.
module csr_machine_trap #(
  parameter int              XLEN        = 64,
  parameter int              NUM_HPM     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  csr_we,
  input  logic [11:0]                           csr_addr,
  input  logic [XLEN-1:0]                       csr_wdata,
  output logic [XLEN-1:0]                       csr_rdata,
  output logic                                  illegal_csr,
  input  logic [XLEN-1:0]                       pc,
  input  logic                                  instr_retired,
  input  logic                                  exc_valid,
  input  logic [4:0]                            exc_cause,
  input  logic [XLEN-1:0]                       exc_tval,
  input  logic                                  mret,
  input  logic                                  irq_ext,
  input  logic                                  irq_timer,
  input  logic                                  irq_soft,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  output logic [1:0]                            priv_lvl,
  output logic                                  trap_taken,
  output logic [XLEN-1:0]                       trap_target,
  output logic                                  dbg_redirect
);

  localparam int          HW       = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [1:0]  PRIV_U   = 2'b00;
  localparam logic [1:0]  PRIV_M   = 2'b11;
  localparam logic [31:0] CNT_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
  localparam logic [XLEN-1:0] MISA = {(XLEN == 64) ? 2'b10 : 2'b01, {(XLEN-2){1'b0}}}
                                     | XLEN'(12'h100);

  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state;

  logic            mstatus_mie, mstatus_mpie;
  logic [1:0]      mstatus_mpp;
  logic            msie, mtie, meie, msip_sw, meip_q, mtip_q;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;
  logic [31:0]     mcounteren, mcountinhibit;
  logic [XLEN-1:0] hpm_cnt [HW];

  logic            rd_impl;
  logic [XLEN-1:0] rd_val;

  always_comb begin
    rd_impl = 1'b1;
    rd_val  = '0;
    case (csr_addr)
      12'h300: begin
        rd_val[3]     = mstatus_mie;
        rd_val[7]     = mstatus_mpie;
        rd_val[12:11] = mstatus_mpp;
      end
      12'h301: rd_val = MISA;
      12'h304: begin
        rd_val[3]  = msie;
        rd_val[7]  = mtie;
        rd_val[11] = meie;
      end
      12'h305: rd_val = mtvec;
      12'h306: rd_val = XLEN'(mcounteren);
      12'h320: rd_val = XLEN'(mcountinhibit);
      12'h340: rd_val = mscratch;
      12'h341: rd_val = mepc;
      12'h342: rd_val = mcause;
      12'h343: rd_val = mtval;
      12'h344: begin
        rd_val[3]  = msip_sw | irq_soft;
        rd_val[7]  = mtip_q;
        rd_val[11] = meip_q;
      end
      12'hB00, 12'hC00, 12'hC01: rd_val = mcycle;
      12'hB02, 12'hC02:          rd_val = minstret;
      default: begin
        rd_impl = 1'b0;
        for (int k = 0; k < NUM_HPM; k++) begin
          if (csr_addr == 12'(32'hB03 + k) || csr_addr == 12'(32'hC03 + k)) begin
            rd_impl = 1'b1;
            rd_val  = hpm_cnt[k];
          end
        end
      end
    endcase
  end

  assign illegal_csr = !rd_impl
                    || (priv_lvl < csr_addr[9:8])
                    || (csr_we && csr_addr[11:10] == 2'b11)
                    || (priv_lvl == PRIV_U && csr_addr[11:5] == 7'h60
                        && !mcounteren[csr_addr[4:0]]);
  assign csr_rdata = illegal_csr ? '0 : rd_val;

  // Event arbitration: exception > interrupt > mret > CSR write.
  logic            pend_ei, pend_si, pend_ti, irq_take, trap_take, mret_take, wr_en;
  logic [4:0]      trap_code;
  logic [XLEN-1:0] tvec_base, trap_pc;

  assign pend_ei   = meip_q & meie;
  assign pend_si   = (msip_sw | irq_soft) & msie;
  assign pend_ti   = mtip_q & mtie;
  assign irq_take  = !exc_valid && instr_retired && (pend_ei || pend_si || pend_ti)
                  && (mstatus_mie || priv_lvl == PRIV_U);
  assign trap_take = exc_valid || irq_take;
  assign mret_take = !trap_take && mret && priv_lvl == PRIV_M;
  assign wr_en     = csr_we && !illegal_csr && !trap_take && !mret_take;
  assign trap_code = exc_valid ? exc_cause : pend_ei ? 5'd11 : pend_si ? 5'd3 : 5'd7;
  assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
  assign trap_pc   = (irq_take && mtvec[1:0] == 2'b01)
                   ? tvec_base + XLEN'({trap_code, 2'b00}) : tvec_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      priv_lvl      <= PRIV_M;
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
      mstatus_mpp   <= PRIV_U;
      msie          <= 1'b0;
      mtie          <= 1'b0;
      meie          <= 1'b0;
      msip_sw       <= 1'b0;
      meip_q        <= 1'b0;
      mtip_q        <= 1'b0;
      mtvec         <= RESET_MTVEC;
      mscratch      <= '0;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
      mcounteren    <= '0;
      mcountinhibit <= '0;
    end else begin
      meip_q <= irq_ext;
      mtip_q <= irq_timer;
      if (trap_take) begin
        mepc         <= pc & ~XLEN'(3);
        mcause       <= {irq_take, {(XLEN-6){1'b0}}, trap_code};
        mtval        <= irq_take ? '0 : exc_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        mstatus_mpp  <= priv_lvl;
        priv_lvl     <= PRIV_M;
      end else if (mret_take) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        priv_lvl     <= mstatus_mpp;
        mstatus_mpp  <= PRIV_U;
      end else if (wr_en) begin
        case (csr_addr)
          12'h300: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
            mstatus_mpp  <= (csr_wdata[12:11] == 2'b11) ? PRIV_M : PRIV_U;
          end
          12'h304: begin
            msie <= csr_wdata[3];
            mtie <= csr_wdata[7];
            meie <= csr_wdata[11];
          end
          12'h305: mtvec         <= {csr_wdata[XLEN-1:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
          12'h306: mcounteren    <= csr_wdata[31:0] & CNT_MASK;
          12'h320: mcountinhibit <= csr_wdata[31:0] & CNT_MASK;
          12'h340: mscratch      <= csr_wdata;
          12'h341: mepc          <= csr_wdata & ~XLEN'(3);
          12'h342: mcause        <= csr_wdata;
          12'h343: mtval         <= csr_wdata;
          12'h344: msip_sw       <= csr_wdata[3];
          default: ;
        endcase
      end
    end
  end

  // A counter write in the same cycle wins over its increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
      for (int k = 0; k < HW; k++) hpm_cnt[k] <= '0;
    end else begin
      if (wr_en && csr_addr == 12'hB00) mcycle <= csr_wdata;
      else if (!mcountinhibit[0])       mcycle <= mcycle + XLEN'(1);
      if (wr_en && csr_addr == 12'hB02)                minstret <= csr_wdata;
      else if (!mcountinhibit[2] && instr_retired)     minstret <= minstret + XLEN'(1);
      for (int k = 0; k < NUM_HPM; k++) begin
        if (wr_en && csr_addr == 12'(32'hB03 + k))        hpm_cnt[k] <= csr_wdata;
        else if (!mcountinhibit[3+k] && hpm_event[k])     hpm_cnt[k] <= hpm_cnt[k] + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      trap_taken  <= 1'b0;
      trap_target <= '0;
    end else if (trap_take || mret_take) begin
      state       <= REDIRECT;
      trap_taken  <= 1'b1;
      trap_target <= trap_take ? trap_pc : mepc;
    end else begin
      state      <= IDLE;
      trap_taken <= 1'b0;
    end
  end

  assign dbg_redirect = (state == REDIRECT);

endmodule

// File: tb/tb_csr_machine_trap.sv
// Scoreboard bench for csr_machine_trap: a CSR-level reference model predicts
// reads, privilege and redirects; a negedge monitor compares.
module tb_csr_machine_trap;
  localparam int          XLEN        = 64;
  localparam int          NUM_HPM     = 4;
  localparam logic [63:0] RESET_MTVEC = 64'h800;

  logic        clk, rst_n;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata, pc, exc_tval, trap_target;
  logic        illegal_csr, instr_retired, exc_valid, mret;
  logic [4:0]  exc_cause;
  logic        irq_ext, irq_timer, irq_soft, trap_taken, dbg_redirect;
  logic [3:0]  hpm_event;
  logic [1:0]  priv_lvl;

  csr_machine_trap #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .RESET_MTVEC(RESET_MTVEC)) dut (
    .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .pc(pc), .instr_retired(instr_retired), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .hpm_event(hpm_event), .priv_lvl(priv_lvl), .trap_taken(trap_taken),
    .trap_target(trap_target), .dbg_redirect(dbg_redirect)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic        mon_en = 1'b0;
  logic [63:0] exp_q [$];
  logic [64:0] rd_q [$];

  // reference model state
  logic [1:0]  m_priv, m_mpp;
  logic        m_mie, m_mpie, m_msip, m_meip, m_mtip;
  logic [11:0] m_ien;
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [31:0] m_cen, m_cinh, cnt_mask;
  logic [63:0] m_cnt [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_priv = 2'd3; m_mpp = 2'd0; m_mie = 0; m_mpie = 0;
    m_msip = 0; m_meip = 0; m_mtip = 0; m_ien = '0;
    m_mtvec = RESET_MTVEC; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
    m_cen = 0; m_cinh = 0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    cnt_mask = 0; cnt_mask[0] = 1'b1; cnt_mask[2] = 1'b1;
    for (int k = 0; k < NUM_HPM; k++) cnt_mask[3+k] = 1'b1;
  endfunction

  function automatic void model_read(input logic [11:0] a, input logic we,
                                     output logic [63:0] v, output logic ill);
    logic impl;
    int   n;
    impl = 1'b1; v = '0; n = int'(a[4:0]);
    case (a)
      12'h300: begin v[3] = m_mie; v[7] = m_mpie; v[12:11] = m_mpp; end
      12'h301: v = 64'h8000_0000_0000_0100;
      12'h304: v = 64'(m_ien);
      12'h305: v = m_mtvec;
      12'h306: v = 64'(m_cen);
      12'h320: v = 64'(m_cinh);
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin v[11] = m_meip; v[7] = m_mtip; v[3] = m_msip | irq_soft; end
      default: begin
        if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[7:5] == 3'd0 &&
            (n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM) || (n == 1 && a[11:8] == 4'hC)))
          v = m_cnt[(n == 1) ? 0 : n];
        else
          impl = 1'b0;
      end
    endcase
    ill = !impl || (m_priv < a[9:8]) || (we && a[11:10] == 2'b11) ||
          (m_priv == 2'd0 && a[11:5] == 7'h60 && !m_cen[n]);
    if (ill) v = '0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [63:0] w);
    case (a)
      12'h300: begin m_mie = w[3]; m_mpie = w[7]; m_mpp = (w[12:11] == 2'b11) ? 2'd3 : 2'd0; end
      12'h304: m_ien = w[11:0] & 12'h888;
      12'h305: m_mtvec = (w[1:0] >= 2'd2) ? (w & ~64'h3) : w;
      12'h306: m_cen = w[31:0] & cnt_mask;
      12'h320: m_cinh = w[31:0] & cnt_mask;
      12'h340: m_mscratch = w;
      12'h341: m_mepc = w & ~64'h3;
      12'h342: m_mcause = w;
      12'h343: m_mtval = w;
      12'h344: m_msip = w[3];
      default: if (a[11:8] == 4'hB) m_cnt[a[4:0]] = w;
    endcase
  endfunction

  function automatic void take_trap(input logic is_irq, input logic [4:0] code, input logic [63:0] tval);
    logic [63:0] base;
    base = m_mtvec & ~64'h3;
    exp_q.push_back((is_irq && m_mtvec[1:0] == 2'd1) ? base + 64'(code) * 4 : base);
    m_mepc   = pc & ~64'h3;
    m_mcause = is_irq ? (64'h8000_0000_0000_0000 | 64'(code)) : 64'(code);
    m_mtval  = is_irq ? 64'h0 : tval;
    m_mpie   = m_mie;
    m_mie    = 1'b0;
    m_mpp    = m_priv;
    m_priv   = 2'd3;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic [63:0] rv;
    logic        ill, pe, ps, pt, irq;
    model_read(csr_addr, csr_we, rv, ill);
    pe  = m_meip && m_ien[11];
    ps  = (m_msip || irq_soft) && m_ien[3];
    pt  = m_mtip && m_ien[7];
    irq = instr_retired && (pe || ps || pt) && (m_mie || m_priv == 2'd0);
    if (!m_cinh[0]) m_cnt[0] = m_cnt[0] + 1;
    if (!m_cinh[2] && instr_retired) m_cnt[2] = m_cnt[2] + 1;
    for (int k = 0; k < NUM_HPM; k++)
      if (!m_cinh[3+k] && hpm_event[k]) m_cnt[3+k] = m_cnt[3+k] + 1;
    if (exc_valid)
      take_trap(1'b0, exc_cause, exc_tval);
    else if (irq)
      take_trap(1'b1, pe ? 5'd11 : ps ? 5'd3 : 5'd7, 64'h0);
    else if (mret && m_priv == 2'd3) begin
      exp_q.push_back(m_mepc);
      m_mie  = m_mpie;
      m_mpie = 1'b1;
      m_priv = m_mpp;
      m_mpp  = 2'd0;
    end else if (csr_we && !ill)
      model_write(csr_addr, csr_wdata);
    m_meip = irq_ext;
    m_mtip = irq_timer;
  endfunction

  // monitor / scoreboard
  logic [63:0] mon_tgt;
  logic [64:0] mon_rd;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("trap_taken", 64'(trap_taken), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        mon_tgt = exp_q.pop_front();
        if (trap_taken) chk("trap_target", trap_target, mon_tgt);
      end
      chk("priv_lvl", 64'(priv_lvl), 64'(m_priv));
      if (rd_q.size() != 0) begin
        mon_rd = rd_q.pop_front();
        chk($sformatf("illegal_csr@%03h", csr_addr), 64'(illegal_csr), 64'(mon_rd[64]));
        chk($sformatf("csr_rdata@%03h", csr_addr), csr_rdata, mon_rd[63:0]);
      end
    end
  end

  // driver tasks
  task automatic set_idle();
    csr_we = 0; csr_addr = 12'h301; csr_wdata = 0; pc = 0; instr_retired = 0;
    exc_valid = 0; exc_cause = 0; exc_tval = 0; mret = 0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0; hpm_event = 0;
  endtask

  task automatic step();
    logic [63:0] v;
    logic        ill;
    model_read(csr_addr, csr_we, v, ill);
    rd_q.push_back({ill, v});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_addr = a; csr_we = 0; step();
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1; step(); csr_we = 0;
  endtask

  task automatic exc(input logic [4:0] c, input logic [63:0] t);
    exc_valid = 1; exc_cause = c; exc_tval = t; step(); exc_valid = 0;
  endtask

  logic [11:0] addr_tab [25];

  initial begin
    addr_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h320, 12'h340,
                 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB01, 12'hB02,
                 12'hB03, 12'hB06, 12'hB07, 12'hC00, 12'hC01, 12'hC02, 12'hC03,
                 12'hC06, 12'hC07, 12'h7C0, 12'h3A0};
    set_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_trap_taken", 64'(trap_taken), 64'h0);
    chk("reset_priv", 64'(priv_lvl), 64'h3);
    chk("reset_dbg_redirect", 64'(dbg_redirect), 64'h0);
    rst_n = 1;
    model_reset();
    mon_en = 1;

    rd(12'h301); rd(12'h305); rd(12'h300); rd(12'h342); rd(12'hB00);

    // drop to U, probe protection, return through exceptions
    wr(12'h341, 64'h100);
    mret = 1; step(); mret = 0;
    rd(12'h300); rd(12'hC00);
    exc(5'd8, 64'h0);
    wr(12'h306, 64'h1);
    wr(12'h341, 64'h180);
    mret = 1; step(); mret = 0;
    rd(12'hC00); rd(12'hC02); rd(12'hC01);
    exc(5'd8, 64'h0);
    wr(12'hC00, 64'h5555);
    rd(12'hB00);

    // vectored timer interrupt
    wr(12'h305, 64'h1001); wr(12'h304, 64'h80); wr(12'h300, 64'h8);
    irq_timer = 1; step(); step();
    instr_retired = 1; pc = 64'h200; step();
    instr_retired = 0; irq_timer = 0;
    rd(12'h342); rd(12'h341); rd(12'h300); rd(12'h344);

    // external beats timer when both pending
    wr(12'h304, 64'h888); wr(12'h300, 64'h8);
    irq_ext = 1; irq_timer = 1; step();
    instr_retired = 1; pc = 64'h3337; step();
    instr_retired = 0; irq_ext = 0; irq_timer = 0;
    rd(12'h342); rd(12'h341);

    // exception beats mret and a CSR write
    wr(12'h340, 64'h55);
    exc_valid = 1; exc_cause = 5'd2; exc_tval = 64'hDEAD; mret = 1;
    csr_we = 1; csr_addr = 12'h340; csr_wdata = 64'h99; step();
    exc_valid = 0; mret = 0; csr_we = 0;
    rd(12'h342); rd(12'h343); rd(12'h340);

    // mret to U
    wr(12'h300, 64'h80); wr(12'h341, 64'h400);
    mret = 1; step(); mret = 0;
    exc(5'd8, 64'h0);
    rd(12'h300);

    // counters
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00); rd(12'hB00); rd(12'hB00);
    wr(12'h320, 64'h4);
    for (int i = 0; i < 6; i++) begin instr_retired = i[0]; rd(12'hB02); end
    wr(12'h320, 64'h0);
    for (int i = 0; i < 4; i++) begin instr_retired = i[0]; rd(12'hB02); end
    instr_retired = 0;
    hpm_event = 4'h1;
    wr(12'hB03, 64'h1234);
    rd(12'hB03);
    hpm_event = 4'h0;
    rd(12'hB03); rd(12'hC03);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      csr_addr      = addr_tab[$urandom_range(0, 24)];
      csr_we        = ($urandom_range(0, 99) < 30);
      csr_wdata     = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) csr_wdata = 64'($urandom_range(0, 4095));
      pc            = {$urandom, $urandom};
      instr_retired = 1'($urandom_range(0, 1));
      exc_valid     = ($urandom_range(0, 99) < 4);
      exc_cause     = 5'($urandom_range(0, 31));
      exc_tval      = {$urandom, $urandom};
      mret          = ($urandom_range(0, 99) < 6);
      hpm_event     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)  irq_ext   = !irq_ext;
      if ($urandom_range(0, 9) == 0)  irq_timer = !irq_timer;
      if ($urandom_range(0, 29) == 0) irq_soft  = !irq_soft;
      step();
    end

    set_idle();
    step(); step();
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);

    // reset while a redirect is showing
    exc(5'd5, 64'h77);
    mon_en = 0;
    chk("pre_rst_trap_taken", 64'(trap_taken), 64'h1);
    rst_n = 0;
    #1;
    chk("rst_trap_taken", 64'(trap_taken), 64'h0);
    chk("rst_dbg_redirect", 64'(dbg_redirect), 64'h0);
    chk("rst_priv", 64'(priv_lvl), 64'h3);
    exp_q.delete();
    rd_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    mon_en = 1;
    rd(12'h305); rd(12'h342); rd(12'hB02);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
